boot_loader: RTL and testbench

Boot-time image copier that holds the core in reset while it copies a fixed-size boot image from an on-chip boot ROM into main memory at the reset vector, then releases the core. It sits between the global reset input and the CPU's reset, taking the place of the pass-through reset path. It reads the ROM, the image source, and drives the memory write port, the image sink. Hardware therefore loads the image instead of the C++ harness.

---
 rtl/boot_loader_if.sv | 25 ++
 rtl/boot_loader.sv | 130 +++++++++++++
 tb/tb_boot_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Bus bundle for the boot image copier: ROM read port and memory write port.
interface boot_loader_if #(
    parameter int unsigned ROM_AW = 8
);
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              mem_wreq;
    logic [31:0]       mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_wack;

    // The copier drives the ROM strobe/address and the memory write request.
    modport master (
        output rom_en, rom_addr, mem_wreq, mem_waddr, mem_wdata, mem_wstrb,
        input  rom_data, mem_wack
    );

    // ROM and memory side.
    modport slave (
        input  rom_en, rom_addr, mem_wreq, mem_waddr, mem_wdata, mem_wstrb,
        output rom_data, mem_wack
    );
endinterface

// File: rtl/boot_loader.sv
// Boot-time image copier: holds the core in reset, copies IMG_WORDS words
// from the boot ROM to memory starting at BASE_ADDR, then releases the core.
// A write that is not acknowledged within TIMEOUT cycles parks the block in
// a sticky error state with the core still held in reset.
module boot_loader #(
    parameter int unsigned IMG_WORDS = 256,
    parameter int unsigned ROM_AW    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          global_rst_n,
    output logic          init_rst,
    output logic          done,
    output logic          err,
    boot_loader_if.master bus
);
    localparam int unsigned   IW       = ROM_AW + 1;
    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(IMG_WORDS - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          rom_en_q, rom_en_d;
    logic          wreq_q, wreq_d;
    logic          init_rst_q, init_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Byte offset of a word index; the add to BASE_ADDR wraps modulo 2^32.
    function automatic logic [31:0] word_offset(input logic [IW-1:0] idx);
        return 32'({idx, 2'b00});
    endfunction

    // Next-state logic; bus outputs are decoded from the next state so that
    // the registered strobes line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE:  state_d = READ;
            READ:  state_d = LATCH;
            LATCH: begin
                wdata_d = bus.rom_data;
                waddr_d = BASE_ADDR + word_offset(idx_q);
                cnt_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (bus.mem_wack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = READ;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        rom_en_d   = (state_d == READ);
        wreq_d     = (state_d == WRITE);
        wstrb_d    = wreq_d ? 4'hF : 4'h0;
        init_rst_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    // State, datapath and output registers; reset aborts any copy in flight.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            waddr_q    <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'h0;
            rom_en_q   <= 1'b0;
            wreq_q     <= 1'b0;
            init_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rom_en_q   <= rom_en_d;
            wreq_q     <= wreq_d;
            init_rst_q <= init_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = idx_q[ROM_AW-1:0];
    assign bus.mem_wreq  = wreq_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign init_rst      = init_rst_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: nominal copy, wait states, timeout and
// its boundary, reset mid-copy, stray acks, single word and address wrap.
module tb_boot_loader;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_bc = 1'b0;
    logic tie_a = 1'b1;
    logic wack_a = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   acc_a;

    logic [31:0] rom_a [0:3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [31:0] rom_bc [0:1] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};

    logic init_rst_a, done_a, err_a;
    logic init_rst_b, done_b, err_b;
    logic init_rst_c, done_c, err_c;

    boot_loader_if #(.ROM_AW(2)) ifa ();
    boot_loader_if #(.ROM_AW(1)) ifb ();
    boot_loader_if #(.ROM_AW(1)) ifc ();

    boot_loader #(.IMG_WORDS(4), .ROM_AW(2), .BASE_ADDR(32'h8000_0000), .TIMEOUT(8)) dut_a (
        .clk(clk), .global_rst_n(rst_a), .init_rst(init_rst_a), .done(done_a), .err(err_a), .bus(ifa.master));
    boot_loader #(.IMG_WORDS(1), .ROM_AW(1), .BASE_ADDR(32'hFFFF_FFFC), .TIMEOUT(8)) dut_b (
        .clk(clk), .global_rst_n(rst_bc), .init_rst(init_rst_b), .done(done_b), .err(err_b), .bus(ifb.master));
    boot_loader #(.IMG_WORDS(2), .ROM_AW(1), .BASE_ADDR(32'hFFFF_FFFC), .TIMEOUT(8)) dut_c (
        .clk(clk), .global_rst_n(rst_bc), .init_rst(init_rst_c), .done(done_c), .err(err_c), .bus(ifc.master));

    always #5 clk = ~clk;

    // Synchronous ROM models: data valid the cycle after the read strobe.
    always @(posedge clk) if (ifa.rom_en) ifa.rom_data <= rom_a[ifa.rom_addr];
    always @(posedge clk) if (ifb.rom_en) ifb.rom_data <= rom_bc[ifb.rom_addr];
    always @(posedge clk) if (ifc.rom_en) ifc.rom_data <= rom_bc[ifc.rom_addr];

    assign ifa.mem_wack = tie_a ? ifa.mem_wreq : wack_a;
    assign ifb.mem_wack = ifb.mem_wreq;
    assign ifc.mem_wack = ifc.mem_wreq;

    // Count accepted writes on DUT A.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) acc_a <= 0;
        else if (ifa.mem_wreq && ifa.mem_wack) acc_a <= acc_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_a(input logic tie, input logic wack);
        rst_a = 1'b0;
        tie_a = tie;
        wack_a = wack;
        repeat (2) @(posedge clk);
        #4 rst_a = 1'b1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_init_rst"}, 32'(init_rst_a), 32'h1);
        chk({tag, "_rom_en"}, 32'(ifa.rom_en), 32'h0);
        chk({tag, "_rom_addr"}, 32'(ifa.rom_addr), 32'h0);
        chk({tag, "_wreq"}, 32'(ifa.mem_wreq), 32'h0);
        chk({tag, "_waddr"}, ifa.mem_waddr, 32'h0);
        chk({tag, "_wdata"}, ifa.mem_wdata, 32'h0);
        chk({tag, "_wstrb"}, 32'(ifa.mem_wstrb), 32'h0);
        chk({tag, "_done"}, 32'(done_a), 32'h0);
        chk({tag, "_err"}, 32'(err_a), 32'h0);
    endtask

    initial begin
        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #2;
        chk_reset_a("rst");
        chk("rst_b_init_rst", 32'(init_rst_b), 32'h1);

        // ---- Nominal copy, ack tied to request ----
        #2 rst_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("nom_read_en", 32'(ifa.rom_en), 32'h1);
            chk("nom_read_addr", 32'(ifa.rom_addr), 32'(k));
            chk("nom_read_wreq", 32'(ifa.mem_wreq), 32'h0);
            step();
            chk("nom_latch_en", 32'(ifa.rom_en), 32'h0);
            chk("nom_latch_wreq", 32'(ifa.mem_wreq), 32'h0);
            step();
            chk("nom_wreq", 32'(ifa.mem_wreq), 32'h1);
            chk("nom_waddr", ifa.mem_waddr, 32'h8000_0000 + 32'(4 * k));
            chk("nom_wdata", ifa.mem_wdata, rom_a[k]);
            chk("nom_wstrb", 32'(ifa.mem_wstrb), 32'hF);
        end
        chk("nom_c12_init_rst", 32'(init_rst_a), 32'h1);
        step();
        chk("nom_c13_init_rst", 32'(init_rst_a), 32'h0);
        chk("nom_done", 32'(done_a), 32'h1);
        chk("nom_err", 32'(err_a), 32'h0);
        chk("nom_done_wreq", 32'(ifa.mem_wreq), 32'h0);
        chk("nom_done_wstrb", 32'(ifa.mem_wstrb), 32'h0);
        chk("nom_acc", 32'(acc_a), 32'd4);

        // ---- Wait states on word 2, stray acks in READ/LATCH/DONE ----
        reset_a(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            wack_a = (k == 0);
            chk("ws_read_en", 32'(ifa.rom_en), 32'h1);
            chk("ws_read_addr", 32'(ifa.rom_addr), 32'(k));
            step();
            wack_a = (k == 1);
            chk("ws_latch_en", 32'(ifa.rom_en), 32'h0);
            chk("ws_latch_wreq", 32'(ifa.mem_wreq), 32'h0);
            step();
            wack_a = (k != 2);
            chk("ws_wreq", 32'(ifa.mem_wreq), 32'h1);
            chk("ws_waddr", ifa.mem_waddr, 32'h8000_0000 + 32'(4 * k));
            chk("ws_wdata", ifa.mem_wdata, rom_a[k]);
            if (k == 2) begin
                for (int i = 1; i <= 5; i++) begin
                    step();
                    wack_a = (i == 5);
                    chk("ws_wait_wreq", 32'(ifa.mem_wreq), 32'h1);
                    chk("ws_wait_waddr", ifa.mem_waddr, 32'h8000_0008);
                    chk("ws_wait_wdata", ifa.mem_wdata, 32'h3333_3333);
                end
            end
        end
        chk("ws_c17_init_rst", 32'(init_rst_a), 32'h1);
        step();
        wack_a = 1'b1;
        chk("ws_c18_init_rst", 32'(init_rst_a), 32'h0);
        chk("ws_done", 32'(done_a), 32'h1);
        step();
        step();
        wack_a = 1'b0;
        chk("ws_stray_done", 32'(done_a), 32'h1);
        chk("ws_stray_wreq", 32'(ifa.mem_wreq), 32'h0);
        chk("ws_stray_rom_en", 32'(ifa.rom_en), 32'h0);
        chk("ws_stray_idx", 32'(ifa.rom_addr), 32'd3);
        chk("ws_acc", 32'(acc_a), 32'd4);

        // ---- Timeout: no ack ever ----
        reset_a(1'b0, 1'b0);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("to_wreq", 32'(ifa.mem_wreq), 32'h1);
            chk("to_err_pending", 32'(err_a), 32'h0);
        end
        step();
        wack_a = 1'b1;
        chk("to_err", 32'(err_a), 32'h1);
        chk("to_wreq_off", 32'(ifa.mem_wreq), 32'h0);
        chk("to_wstrb_off", 32'(ifa.mem_wstrb), 32'h0);
        chk("to_init_rst", 32'(init_rst_a), 32'h1);
        repeat (4) step();
        chk("to_err_sticky", 32'(err_a), 32'h1);
        chk("to_done_stuck", 32'(done_a), 32'h0);
        chk("to_init_rst_stuck", 32'(init_rst_a), 32'h1);
        chk("to_wreq_stuck", 32'(ifa.mem_wreq), 32'h0);

        // ---- Timeout boundary: ack in the 8th WRITE cycle ----
        reset_a(1'b0, 1'b0);
        step();
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            wack_a = (i == 8);
        end
        chk("tb_last_wreq", 32'(ifa.mem_wreq), 32'h1);
        step();
        tie_a = 1'b1;
        chk("tb_err", 32'(err_a), 32'h0);
        chk("tb_next_read", 32'(ifa.rom_en), 32'h1);
        chk("tb_next_addr", 32'(ifa.rom_addr), 32'd1);
        repeat (9) step();
        chk("tb_done", 32'(done_a), 32'h1);
        chk("tb_err_final", 32'(err_a), 32'h0);

        // ---- Reset mid-copy during word 2 WRITE ----
        reset_a(1'b1, 1'b0);
        repeat (9) step();
        chk("mid_wreq", 32'(ifa.mem_wreq), 32'h1);
        chk("mid_waddr", ifa.mem_waddr, 32'h8000_0008);
        #1 rst_a = 1'b0;
        #1;
        chk_reset_a("mid_async");
        repeat (2) @(posedge clk);
        #4 rst_a = 1'b1;
        repeat (3) step();
        chk("mid_restart_wreq", 32'(ifa.mem_wreq), 32'h1);
        chk("mid_restart_waddr", ifa.mem_waddr, 32'h8000_0000);
        chk("mid_restart_wdata", ifa.mem_wdata, 32'h1111_1111);

        // ---- Single word and address wrap ----
        @(posedge clk);
        #4 rst_bc = 1'b1;
        repeat (3) step();
        chk("one_waddr", ifb.mem_waddr, 32'hFFFF_FFFC);
        chk("one_wdata", ifb.mem_wdata, 32'hDEAD_BEEF);
        chk("one_c3_init_rst", 32'(init_rst_b), 32'h1);
        chk("wrap_first_waddr", ifc.mem_waddr, 32'hFFFF_FFFC);
        step();
        chk("one_c4_init_rst", 32'(init_rst_b), 32'h0);
        chk("one_done", 32'(done_b), 32'h1);
        repeat (2) step();
        chk("wrap_wreq", 32'(ifc.mem_wreq), 32'h1);
        chk("wrap_second_waddr", ifc.mem_waddr, 32'h0000_0000);
        chk("wrap_second_wdata", ifc.mem_wdata, 32'hCAFE_F00D);
        step();
        chk("wrap_done", 32'(done_c), 32'h1);
        chk("wrap_init_rst", 32'(init_rst_c), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
